// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared state encoding and counter-width helper for the fade sequencer
package pwm_fade_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pwm_fade_ctrl_tick_gen.sv
// tick_gen: prescaler producing a 1-clk tick every DIV enabled clocks, clearable
module tick_gen
  import pwm_fade_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == LAST;
  // count while enabled, wrap after the tick cycle, clear restarts the period
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: breathing sequencer ramping a PWM duty word between min and max with end holds
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 12000,
  parameter int HOLD_TICKS = 250
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_min_duty,
  input  logic [PWM_BITS-1:0] i_max_duty,
  input  logic [PWM_BITS-1:0] i_step,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy,
  output logic                o_cycle_done,
  output logic                o_cfg_err
);
  localparam int HW = cnt_w(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  state_t state;
  logic tick, cfg_ok;
  logic [HW-1:0] hold_cnt;
  logic [PWM_BITS-1:0] min_r, max_r, step_r, up_duty, dn_duty, above_min;
  logic [PWM_BITS:0] sum;
  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (i_clk),
    .reset(i_reset),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick)
  );
  // saturating next-duty values; the add carries into an extra bit and the subtract compares distance to min first
  always_comb begin
    sum       = {1'b0, o_duty} + {1'b0, step_r};
    up_duty   = sum >= {1'b0, max_r} ? max_r : sum[PWM_BITS-1:0];
    above_min = o_duty - min_r;
    dn_duty   = above_min <= step_r ? min_r : o_duty - step_r;
    cfg_ok    = i_max_duty > i_min_duty && i_step != '0;
  end
  // sequencer FSM with registered outputs; disable overrides every state
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state        <= IDLE;
      o_duty       <= '0;
      o_busy       <= 1'b0;
      o_cycle_done <= 1'b0;
      o_cfg_err    <= 1'b0;
      hold_cnt     <= '0;
      min_r        <= '0;
      max_r        <= '0;
      step_r       <= '0;
    end else begin
      o_cycle_done <= 1'b0;
      if (!i_enable) begin
        state     <= IDLE;
        o_duty    <= i_min_duty;
        o_busy    <= 1'b0;
        o_cfg_err <= 1'b0;
        hold_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            o_duty <= i_min_duty;
            if (!o_cfg_err) begin
              min_r  <= i_min_duty;
              max_r  <= i_max_duty;
              step_r <= i_step;
              if (cfg_ok) begin
                state  <= UP;
                o_busy <= 1'b1;
              end else o_cfg_err <= 1'b1;
            end
          end
          UP:
            if (tick) begin
              o_duty <= up_duty;
              if (up_duty == max_r) begin
                state    <= HOLD_HI;
                hold_cnt <= '0;
              end
            end
          HOLD_HI:
            if (tick) begin
              if (hold_cnt == HOLD_LAST) state <= DOWN;
              else hold_cnt <= hold_cnt + 1'b1;
            end
          DOWN:
            if (tick) begin
              o_duty <= dn_duty;
              if (dn_duty == min_r) begin
                state    <= HOLD_LO;
                hold_cnt <= '0;
              end
            end
          HOLD_LO:
            if (tick) begin
              if (hold_cnt == HOLD_LAST) begin
                state        <= UP;
                o_cycle_done <= 1'b1;
              end else hold_cnt <= hold_cnt + 1'b1;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule
